// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: mult/div op-codes, MDU state encoding,
// and the conditional two's-complement negate used for abs/sign fix-up.
package mips_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_CALC   = 2'b01;
    localparam logic [1:0] ST_FINISH = 2'b10;

    // Helper width; callers extend into and slice out of this.
    localparam int NEG_W = 64;

    // Negate when en=1; abs(x) is cond_neg(x, sign(x)).
    function automatic logic [NEG_W-1:0] cond_neg(input logic [NEG_W-1:0] x, input logic en);
        return en ? (~x + NEG_W'(1)) : x;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit producing HI/LO; one shift-add or restoring step per cycle.
// Latency DATA_WIDTH+1 cycles from accepted start to done; one op per DATA_WIDTH+2 cycles back-to-back.
// No backpressure: start/MTHI/MTLO are simply ignored while busy, start beats MTHI/MTLO in IDLE.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic                  write_hi,
    input  logic                  write_lo,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);

    logic [1:0]     state;
    logic [CW-1:0]  cnt;
    logic [1:0]     op_q;
    logic [W-1:0]   addend;     // multiplicand for multiply, divisor for divide
    logic           neg_q;      // negate product / quotient
    logic           neg_r;      // negate remainder
    logic [2*W-1:0] acc;        // {upper, lower}: product, or {remainder, quotient}

    // Operand magnitudes at launch
    logic             is_signed;
    logic             is_div_in;
    logic             sa;
    logic             sb;
    logic             b_zero;
    logic [NEG_W-1:0] abs_a_full;
    logic [NEG_W-1:0] abs_b_full;
    logic [W-1:0]     mag_a;
    logic [W-1:0]     mag_b;

    assign is_signed = ~op[0];
    assign is_div_in = op[1];
    assign sa        = is_signed & operand_a[W-1];
    assign sb        = is_signed & operand_b[W-1];
    assign b_zero    = (operand_b == '0);

    assign abs_a_full = cond_neg({{(NEG_W-W){operand_a[W-1]}}, operand_a}, sa);
    assign abs_b_full = cond_neg({{(NEG_W-W){operand_b[W-1]}}, operand_b}, sb);
    assign mag_a      = abs_a_full[W-1:0];
    assign mag_b      = abs_b_full[W-1:0];

    // Multiply step: add multiplicand when the current multiplier bit is set, then shift right
    logic [W:0]     mul_sum;
    logic [2*W-1:0] acc_mul;

    assign mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, addend} : '0);
    assign acc_mul = {mul_sum, acc[W-1:1]};

    // Restoring divide step: shift next dividend bit into the remainder and trial-subtract
    logic [W:0]     rem_sh;
    logic [W+1:0]   diff;
    logic           take;
    logic [2*W-1:0] acc_div;

    assign rem_sh  = acc[2*W-1:W-1];
    assign diff    = {1'b0, rem_sh} - {2'b00, addend};
    assign take    = ~diff[W+1];
    assign acc_div = take ? {diff[W-1:0],   acc[W-2:0], 1'b1}
                          : {rem_sh[W-1:0], acc[W-2:0], 1'b0};

    // Sign fix-up at FINISH
    logic [2*W-1:0]   prod_fix;
    logic [NEG_W-1:0] quo_full;
    logic [NEG_W-1:0] rem_full;

    assign prod_fix = neg_q ? (~acc + (2*W)'(1)) : acc;
    assign quo_full = cond_neg(NEG_W'(acc[W-1:0]), neg_q);
    assign rem_full = cond_neg(NEG_W'(acc[2*W-1:W]), neg_r);

    logic unused_bits;
    assign unused_bits = ^{abs_a_full[NEG_W-1:W], abs_b_full[NEG_W-1:W],
                           quo_full[NEG_W-1:W], rem_full[NEG_W-1:W], diff[W], op_q[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            op_q   <= OP_MULT;
            addend <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            acc    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= ST_CALC;
                        addend <= is_div_in ? mag_b : mag_a;
                        acc    <= {{W{1'b0}}, is_div_in ? mag_a : mag_b};
                        // Divide-by-zero: all-ones quotient stays positive, remainder |a| re-signs to raw a
                        neg_q  <= (sa ^ sb) & ~(is_div_in & b_zero);
                        neg_r  <= is_div_in & sa;
                    end else begin
                        if (write_hi) hi <= wdata;
                        if (write_lo) lo <= wdata;
                    end
                end
                ST_CALC: begin
                    acc <= op_q[1] ? acc_div : acc_mul;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST_ITER) state <= ST_FINISH;
                end
                ST_FINISH: begin
                    if (op_q[1]) begin
                        hi <= rem_full[W-1:0];
                        lo <= quo_full[W-1:0];
                    end else begin
                        hi <= prod_fix[2*W-1:W];
                        lo <= prod_fix[W-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized + directed bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        write_hi;
    logic        write_lo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .write_hi(write_hi), .write_lo(write_lo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, from plain integer arithmetic
    task automatic model_result(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] rh, output logic [31:0] rl);
        longint          sp;
        longint unsigned up;
        longint          sq;
        longint          sr;
        logic [63:0]     v;
        case (mop)
            2'b00: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                v  = sp;
                rh = v[63:32];
                rl = v[31:0];
            end
            2'b01: begin
                up = longint'({32'b0, a}) * longint'({32'b0, b});
                v  = up;
                rh = v[63:32];
                rl = v[31:0];
            end
            2'b10: begin
                if (b == 32'd0) begin
                    rl = 32'hFFFF_FFFF;
                    rh = a;
                end else begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    v  = sq;
                    rl = v[31:0];
                    v  = sr;
                    rh = v[31:0];
                end
            end
            default: begin
                if (b == 32'd0) begin
                    rl = 32'hFFFF_FFFF;
                    rh = a;
                end else begin
                    rl = a / b;
                    rh = a % b;
                end
            end
        endcase
    endtask

    // Reference model: remaining-latency counter plus pending result
    int          m_cnt = 0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] m_rh;
    logic [31:0] m_rl;

    always @(posedge clk) begin
        m_done = 1'b0;
        if (rst) begin
            m_cnt  = 0;
            m_busy = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_hi   = m_rh;
                m_lo   = m_rl;
                m_done = 1'b1;
                m_busy = 1'b0;
            end
        end else if (start) begin
            model_result(op, operand_a, operand_b, m_rh, m_rl);
            m_cnt  = 33;
            m_busy = 1'b1;
        end else begin
            if (write_hi) m_hi = wdata;
            if (write_lo) m_lo = wdata;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'b0, busy}, {31'b0, m_busy});
            chk("done", {31'b0, done}, {31'b0, m_done});
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch an op and wait for done; returns cycles from the start edge to done
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output int n);
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        tick();
        start = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        n = 0;
        while (!done && n < 60) begin
            tick();
            n++;
        end
        if (!done) chk("done_timeout", 32'(n), 32'd33);
    endtask

    task automatic run_lit(input string name, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int n;
        run_op(o, a, b, n);
        chk({name, "_lat"}, 32'(n), 32'd33);
        chk({name, "_hi"}, hi, eh);
        chk({name, "_lo"}, lo, el);
    endtask

    initial begin
        int n;
        int busy_cycles;
        int saw_done;
        logic [31:0] ph;
        logic [31:0] pl;

        rst = 1'b1; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
        write_hi = 1'b0; write_lo = 1'b0; wdata = '0;

        // Pin the model itself to hand-computed values
        model_result(2'b00, 32'hFFFF_FFFD, 32'd7, ph, pl);
        chk("model_mult", pl, 32'hFFFF_FFEB);
        model_result(2'b10, 32'hFFFF_FFF9, 32'd2, ph, pl);
        chk("model_div_rem", ph, 32'hFFFF_FFFF);
        model_result(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, ph, pl);
        chk("model_ovf", pl, 32'h8000_0000);

        tick(); tick();
        chk_en = 1'b1;
        rst = 1'b0;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        tick();

        // Busy must stay high for exactly 33 cycles
        op = 2'b01; operand_a = 32'hFFFF_FFFF; operand_b = 32'hFFFF_FFFF; start = 1'b1;
        tick();
        start = 1'b0;
        busy_cycles = 0;
        while (busy && busy_cycles < 60) begin
            busy_cycles++;
            tick();
        end
        chk("multu_busy_cycles", 32'(busy_cycles), 32'd33);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);
        tick();

        run_lit("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        tick();
        run_lit("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        tick();
        run_lit("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        tick();
        run_lit("divu", 2'b11, 32'd7, 32'd2, 32'd1, 32'd3);
        tick();
        run_lit("div_zero", 2'b10, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
        tick();
        run_lit("div_zero_neg", 2'b10, 32'h8765_4321, 32'd0, 32'h8765_4321, 32'hFFFF_FFFF);
        tick();
        run_lit("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        tick();

        // Start and MTHI during a MULT are ignored; a start in the done cycle is accepted
        op = 2'b00; operand_a = 32'd1000; operand_b = 32'hFFFF_FFFE; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        op = 2'b11; operand_a = 32'd9; operand_b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0; write_hi = 1'b1; wdata = 32'hDEAD_BEEF;
        tick();
        write_hi = 1'b0;
        n = 6;
        while (!done && n < 60) begin
            tick();
            n++;
        end
        chk("inflight_lat", 32'(n), 32'd33);
        chk("inflight_hi", hi, 32'hFFFF_FFFF);
        chk("inflight_lo", lo, 32'hFFFF_F830);
        run_lit("b2b_divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        tick();

        // MTLO in idle: immediate update, no done
        write_lo = 1'b1; wdata = 32'hCAFE_BABE;
        tick();
        write_lo = 1'b0;
        chk("mtlo_lo", lo, 32'hCAFE_BABE);
        chk("mtlo_done", {31'b0, done}, 32'd0);
        tick();

        // start beats MTHI in the same cycle
        write_hi = 1'b1; wdata = 32'h5555_AAAA;
        op = 2'b11; operand_a = 32'd7; operand_b = 32'd2; start = 1'b1;
        tick();
        write_hi = 1'b0; start = 1'b0;
        chk("start_wins_busy", {31'b0, busy}, 32'd1);
        chk("start_wins_hi_held", hi, 32'd2);
        n = 0;
        while (!done && n < 60) begin
            tick();
            n++;
        end
        chk("start_wins_res_hi", hi, 32'd1);
        chk("start_wins_res_lo", lo, 32'd3);
        tick();

        // Reset in the middle of a DIV
        op = 2'b10; operand_a = 32'd12345; operand_b = 32'd17; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        saw_done = 0;
        repeat (40) begin
            tick();
            if (done) saw_done++;
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);
        run_lit("after_abort", 2'b10, 32'd12345, 32'd17, 32'd3, 32'd726);
        tick();

        // Randomized traffic with ignored junk while busy and occasional MTHI/MTLO in idle
        for (int i = 0; i < 150; i++) begin
            op = 2'($urandom_range(0, 3));
            operand_a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0: operand_b = 32'd0;
                1: operand_b = 32'hFFFF_FFFF;
                2: operand_b = 32'($urandom_range(1, 20));
                default: operand_b = $urandom;
            endcase
            start = 1'b1;
            tick();
            start = 1'b0;
            n = 0;
            while (!done && n < 60) begin
                start = 1'($urandom_range(0, 1));
                write_hi = 1'($urandom_range(0, 1));
                write_lo = 1'($urandom_range(0, 1));
                wdata = $urandom;
                operand_a = $urandom;
                operand_b = $urandom;
                tick();
                n++;
            end
            start = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
            chk("rand_lat", 32'(n), 32'd33);
            if ($urandom_range(0, 3) == 0) begin
                write_hi = 1'($urandom_range(0, 1));
                write_lo = 1'($urandom_range(0, 1));
                wdata = $urandom;
                tick();
                write_hi = 1'b0; write_lo = 1'b0;
            end
        end

        repeat (3) tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
